serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
- Bit-serial adder stage built around the mux-based 1-bit full adder.
- Accepts two parallel WIDTH-bit operands and a carry-in over a valid/ready handshake.
- Feeds the full adder one bit per clock, LSB first, and registers the carry back into its cin.
- Assembles the sum bits and presents {cout, sum} downstream over a second valid/ready handshake.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), width of the bit counter; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  upstream operands valid
- in_ready  output  1  block can accept operands
- a_in  input  WIDTH  operand A
- b_in  input  WIDTH  operand B
- cin_in  input  1  initial carry-in
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sum_out  output  WIDTH  sum result
- cout_out  output  1  final carry-out

Behaviour:
- All state is updated on the rising edge of clk. rst_n is sampled on that edge only.
- FSM states are IDLE, RUN and DONE. Reset forces IDLE.
- Reset values: a_sh, b_sh and sum_sh = 0; carry = 0; cnt = 0; out_valid = 0; sum_out = 0; cout_out = 0.
- in_ready = (state == IDLE) && rst_n. It is 0 in RUN and DONE.
- IDLE:
  - On in_valid && in_ready at edge T: a_sh <= a_in; b_sh <= b_in; carry <= cin_in; cnt <= 0; sum_sh <= 0; state -> RUN.
  - With no handshake, the state holds.
- RUN (one bit per cycle):
  - The full adder sees a = a_sh[0], b = b_sh[0], cin = carry.
  - On each edge: sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]}; carry <= fa_cout; a_sh and b_sh shift right with 0 fill; cnt <= cnt + 1.
  - When cnt == WIDTH-1 on an edge, that edge performs the final bit step and sets state -> DONE.
  - in_valid is ignored in RUN.
- Latency: the accept edge is T. out_valid is first high after edge T+WIDTH, i.e. WIDTH+1 cycles from accept to result.
- DONE:
  - out_valid = 1; sum_out = sum_sh; cout_out = carry.
  - All outputs are held stable while out_ready = 0, for any number of cycles.
  - On out_valid && out_ready: state -> IDLE, and in_ready is 1 in the following cycle.
  - There is no same-cycle output-accept plus input-accept. Minimum issue interval is WIDTH+2 cycles.
- Outside DONE: out_valid = 0. sum_out and cout_out are don't-care, but must not be X after reset.
- Arithmetic: {cout_out, sum_out} == a_in + b_in + cin_in, as unsigned with width WIDTH+1. No overflow flag.
- Reset mid-operation (rst_n low in RUN or DONE): on that edge, all state returns to reset values and the in-flight result is discarded with no out_valid pulse. in_ready is 1 in the first cycle with rst_n high.
- in_valid held high with stable operands across an accept is captured exactly once.

Decomposition:
- Shared package/include file: state encodings ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2 (2'd3 is unused and recovers to IDLE), plus the default WIDTH constant.
- One sub-module: the existing 1-bit full adder fa_mux41, instantiated once. The bit datapath goes through it with no inline adder.
- The control FSM, shift registers and counter are local to serial_adder_ctrl.

Test Plan (WIDTH = 8):
- 0x00 + 0x00, cin 0, out_ready = 1 -> after 9 cycles: sum 0x00, cout 0; out_valid high exactly 1 cycle; in_ready back the next cycle.
- 0xFF + 0x01, cin 0 -> sum 0x00, cout 1. Then 0x3C + 0x42, cin 0 -> sum 0x7E, cout 0.
- 0xA5 + 0x5A, cin 1 -> sum 0x00, cout 1 (full carry ripple). Assert out_valid first high exactly WIDTH edges after accept.
- Backpressure: out_ready = 0 for 5 cycles in DONE, with in_valid = 1 and new operands driven -> sum/cout stable, in_ready 0, new operands not captured; result accepted on out_ready.
- Reset mid-RUN after 3 bit steps (rst_n low 1 cycle) -> no out_valid, in_ready 1 the cycle after release; next op 0x10 + 0x20 gives 0x30, cout 0.
- Random: 500 random a/b/cin with random out_ready stalls -> every result equals the reference model a+b+cin, with no lost or duplicated transactions.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// serial_adder_ctrl_pkg: FSM state encodings and default width for the bit-serial adder
package serial_adder_ctrl_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/serial_adder_ctrl_fa_mux41.sv
// fa_mux41: 1-bit full adder built from two 4:1 muxes selected by {a, b}
module fa_mux41 (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic [1:0] w_sel;
  logic [3:0] w_sum_tbl;
  logic [3:0] w_cout_tbl;
  assign w_sel      = {a, b};
  assign w_sum_tbl  = {cin, ~cin, ~cin, cin};
  assign w_cout_tbl = {1'b1, cin, cin, 1'b0};
  assign sum        = w_sum_tbl[w_sel];
  assign cout       = w_cout_tbl[w_sel];
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder, LSB first through one full adder, with valid/ready on both sides
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
);
  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic             w_fa_sum;
  logic             w_fa_cout;
  fa_mux41 u_fa (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .cin  (r_carry),
    .sum  (w_fa_sum),
    .cout (w_fa_cout)
  );
  assign in_ready  = (r_state == ST_IDLE) && rst_n;
  assign out_valid = (r_state == ST_DONE);
  assign sum_out   = r_sum_sh;
  assign cout_out  = r_carry;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (in_valid) begin
          r_a_sh   <= a_in;
          r_b_sh   <= b_in;
          r_carry  <= cin_in;
          r_cnt    <= '0;
          r_sum_sh <= '0;
          r_state  <= ST_RUN;
        end
        ST_RUN: begin
          r_sum_sh <= {w_fa_sum, r_sum_sh[WIDTH-1:1]};
          r_carry  <= w_fa_cout;
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= ST_DONE;
        end
        ST_DONE: if (out_ready) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed and randomized checks of the bit-serial adder at WIDTH = 8
module tb_serial_adder_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       cin_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum_out;
  logic       cout_out;
  int         errors = 0;
  int         checks = 0;
  int         hs = 0;
  always #5 clk = ~clk;
  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .cin_in    (cin_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .cout_out  (cout_out)
  );
  always @(posedge clk) if (rst_n && out_valid && out_ready) hs++;
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic c);
    int n = 0;
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    a_in = a; b_in = b; cin_in = c; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
  endtask
  task automatic finish_op(input int stall);
    out_ready = 1'b0;
    repeat (stall) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask
  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0; cin_in = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if ({cout_out, sum_out} !== 9'h000) begin errors++; $display("FAIL reset_result got=%h exp=000", {cout_out, sum_out}); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low got=%b exp=0", in_ready); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_high got=%b exp=1", in_ready); end
    @(negedge clk);
  endtask
  task automatic test_basic;
    int lat;
    start_op(8'h00, 8'h00, 1'b0);
    wait_valid(lat);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_timeout got=%b exp=1", out_valid); end
    checks++; if ({cout_out, sum_out} !== 9'h000) begin errors++; $display("FAIL basic_result got=%h exp=000", {cout_out, sum_out}); end
    finish_op(0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready_back got=%b exp=1", in_ready); end
  endtask
  task automatic test_vectors;
    logic [7:0] va [2] = '{8'hFF, 8'h3C};
    logic [7:0] vb [2] = '{8'h01, 8'h42};
    logic [8:0] ve [2] = '{9'h100, 9'h07E};
    int lat;
    for (int i = 0; i < 2; i++) begin
      start_op(va[i], vb[i], 1'b0);
      wait_valid(lat);
      checks++; if ({cout_out, sum_out} !== ve[i]) begin errors++; $display("FAIL vector%0d got=%h exp=%h", i, {cout_out, sum_out}, ve[i]); end
      finish_op(0);
    end
  endtask
  task automatic test_ripple;
    int lat;
    start_op(8'hA5, 8'h5A, 1'b1);
    wait_valid(lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL ripple_latency got=%0d exp=8", lat); end
    checks++; if ({cout_out, sum_out} !== 9'h100) begin errors++; $display("FAIL ripple_result got=%h exp=100", {cout_out, sum_out}); end
    finish_op(0);
  endtask
  task automatic test_backpressure;
    int lat;
    start_op(8'h12, 8'h34, 1'b0);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a_in = 8'hEE; b_in = 8'hEE; cin_in = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid%0d got=%b exp=1", i, out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d got=%b exp=0", i, in_ready); end
      checks++; if ({cout_out, sum_out} !== 9'h046) begin errors++; $display("FAIL bp_hold%0d got=%h exp=046", i, {cout_out, sum_out}); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got=%b%b exp=01", out_valid, in_ready); end
    repeat (12) @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_no_capture got=%b%b exp=01", out_valid, in_ready); end
  endtask
  task automatic test_reset_mid_run;
    int lat;
    int seen = 0;
    start_op(8'h77, 8'h11, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (out_valid) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_discard got=%0d exp=0", seen); end
    start_op(8'h10, 8'h20, 1'b0);
    wait_valid(lat);
    checks++; if ({cout_out, sum_out} !== 9'h030) begin errors++; $display("FAIL midrst_next got=%h exp=030", {cout_out, sum_out}); end
    finish_op(0);
  endtask
  task automatic test_random;
    int lat;
    int hs0 = hs;
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [8:0] exp_r;
    for (int i = 0; i < 500; i++) begin
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
      exp_r = {1'b0, a} + {1'b0, b} + {8'd0, c};
      start_op(a, b, c);
      wait_valid(lat);
      checks++; if (out_valid !== 1'b1 || {cout_out, sum_out} !== exp_r) begin errors++; $display("FAIL rand%0d a=%h b=%h c=%b got=%b/%h exp=1/%h", i, a, b, c, out_valid, {cout_out, sum_out}, exp_r); end
      finish_op(int'($urandom_range(0, 3)));
    end
    checks++; if (hs - hs0 !== 500) begin errors++; $display("FAIL rand_count got=%0d exp=500", hs - hs0); end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_vectors;
    test_ripple;
    test_backpressure;
    test_reset_mid_run;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
